uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, replacing the single-byte transmitter on the FPGA main board's serial links. It accepts words over a valid/ready handshake, buffers up to FIFO_DEPTH of them, and serialises them back-to-back on `tx`. The frame format is set at elaboration time: data width, parity mode and stop-bit count. Each bit lasts exactly CLKS_PER_BIT clocks.

## Interface
- CLK_FREQ, 48000000, system clock frequency in Hz
- BAUD_RATE, 480000, line rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division, must be ≥ 2)
- DATA_BITS, 8, payload width, legal 5..9
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 16, buffer depth, power of two ≥ 2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- s_data  input  DATA_BITS  word to send
- s_valid  input  1  s_data valid
- s_ready  output  1  FIFO can accept a word
- tx  output  1  UART line, idle high
- tx_busy  output  1  frame in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  words stored, 0..FIFO_DEPTH

## Operation
- Reset (asserted low, asynchronous):
  - tx=1, tx_busy=0, s_ready=1, fifo_count=0.
  - FIFO pointers cleared; state = IDLE.
  - Takes effect immediately, including mid-frame: `tx` returns high and buffered words are discarded.
- Write rule:
  - A word is accepted on a rising edge where s_valid && s_ready.
  - s_ready = (fifo_count != FIFO_DEPTH), registered-count based.
  - s_data is sampled only on the accepting edge.
- Pop rule:
  - The FSM pops one word when entering START.
  - The popped word is latched into a shift register; parity is computed from the latched word.
  - Later changes on s_data therefore never corrupt a frame.
- Same-edge write and pop: fifo_count is unchanged. When full, s_ready=0, so a same-cycle pop does not admit a write that cycle.
- Frame, LSB first: start (0), DATA_BITS data bits, optional parity, STOP_BITS stop bits (1).
  - Frame length = 1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS bits.
  - Even parity bit = ^data; odd parity bit = ~^data.
- FSM states and transitions:
  - IDLE→START when fifo_count != 0.
  - START→DATA after 1 bit time.
  - DATA→PARITY after DATA_BITS bit times, or DATA→STOP if PARITY_MODE==0.
  - PARITY→STOP after 1 bit time.
  - STOP→START after STOP_BITS bit times if the FIFO is non-empty, otherwise STOP→IDLE.
- Outputs per state: tx_busy=1 in every state except IDLE; tx=1 in IDLE.
- Illegal parameter values stop elaboration via an initial-block check. There is no run-time fallback.

## Timing
- Latency from an accept into an empty, idle FIFO at edge N:
  - The FSM sees fifo_count=1 after edge N.
  - At edge N+1 it pops, drives tx=0 and sets tx_busy=1.
  - tx_busy and the start bit are therefore visible from edge N+1.
- Bit timing: every bit, including each stop bit, holds `tx` for exactly CLKS_PER_BIT clocks. The bit counter runs 0..CLKS_PER_BIT-1 with no extra cycle.
- Back-to-back frames: if the FIFO is non-empty on the last cycle of the final stop bit, the next start bit begins on the following edge. There is zero idle gap.
- tx_busy deasserts on the edge after the last stop-bit cycle, and only when the FIFO is empty.
- fifo_count updates on the edge of the accept or pop. s_ready follows in the same cycle, since it is derived from the registered count.
- Pointer wrap: pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_count, not by pointer compare.

## Test plan
- Defaults (8N1, 100 clk/bit); push 0x55 once:
  - tx low from edge N+1.
  - Bit sequence 0,1,0,1,0,1,0,1,0,1, each exactly 100 clocks.
  - tx_busy high for 1000 clocks, then tx=1 and fifo_count=0.
- PARITY_MODE=1; push 0xA7:
  - Data bits 1,1,1,0,0,1,0,1.
  - Parity bit 1 (five ones).
  - Frame 11 bits = 1100 clocks.
- DATA_BITS=7, PARITY_MODE=2, STOP_BITS=2; push 0x41:
  - 7 data bits 1,0,0,0,0,0,1.
  - Odd parity bit 1.
  - Two stop bits totalling 200 clocks.
  - Frame 1100 clocks.
- FIFO_DEPTH=4; hold s_valid=1 with an incrementing pattern starting at 0x00:
  - First deassertion of s_ready comes after 5 accepts (one already popped).
  - fifo_count never exceeds 4.
  - Serial output is 0x00,0x01,… in order, with no loss or duplication.
  - No idle gap between frames.
- Reset asserted low 350 clocks into a frame with 3 words queued:
  - tx=1, tx_busy=0, fifo_count=0, s_ready=1 immediately, before any clock edge.
  - After release, no residual frame is sent.
  - A new push transmits normally.
- Change s_data every cycle while a frame is in progress:
  - The transmitted word and its parity match the value sampled on the accept edge.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Purpose: write-side handshake bundle for uart_tx_fifo (word, valid, ready).
// Latency: none, plain wires.
// Backpressure: s_ready low means the transmitter's buffer is full.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] s_data;
   logic                 s_valid;
   logic                 s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: UART transmitter with a FIFO_DEPTH-word buffer, frame format fixed at elaboration.
// Latency: a word accepted into an empty idle buffer starts its start bit on the next edge.
// Backpressure: s_ready drops while the buffer holds FIFO_DEPTH words; frames run back-to-back.
module uart_tx_fifo #(
   parameter int CLK_FREQ    = 48000000,
   parameter int BAUD_RATE   = 480000,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   uart_tx_fifo_if.slave                 s,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int CPB = CLK_FREQ / BAUD_RATE;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int BCW = (CPB >= 2) ? $clog2(CPB) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   // Illegal frame or buffer geometry is rejected while elaborating.
   if (CPB < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
       (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $fatal(1, "uart_tx_fifo: illegal parameter combination");
   end

   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]        count_q, count_d;
   logic [2:0]           state_q, state_d;
   logic [BCW-1:0]       baud_q, baud_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 push, pop, bit_end;
   logic [DATA_BITS-1:0] head;

   // Full/empty come from the registered count; pointers simply wrap.
   assign s.s_ready  = (count_q != CW'(FIFO_DEPTH));
   assign push       = s.s_valid && s.s_ready;
   assign bit_end    = (baud_q == BCW'(CPB - 1));
   assign head       = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign tx_busy    = (state_q != S_IDLE);

   // Frame sequencer: picks the next state, bit counters and the pop request.
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + BCW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == 4'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (count_q != '0) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            baud_d  = '0;
            bit_d   = '0;
         end
      endcase
      // The frame owns a private copy of the word, so later buffer or input changes cannot leak in.
      if (pop) begin
         shift_d = head;
         par_d   = (PARITY_MODE == 1) ? ^head : ~^head;
      end
   end

   // Occupancy: a simultaneous push and pop leaves the count unchanged.
   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Line level is decoded straight from registered state so reset forces it high at once.
   always_comb begin
      tx = 1'b1;
      case (state_q)
         S_START:  tx = 1'b0;
         S_DATA:   tx = shift_q[0];
         S_PARITY: tx = par_q;
         default:  tx = 1'b1;
      endcase
   end

   // Buffer storage needs no reset; reads are gated by a non-zero count.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= s.s_data;
   end

   // Control state and buffer pointers; reset discards any frame and queued words.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         par_q    <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         count_q <= count_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

endmodule
